fifo_rd_stream: RTL



---
 rtl/fifo_rd_pkg.sv | 6 +
 rtl/fifo_rd_stream.sv | 119 +++++++++++
 2 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types for the asynchronous FIFO read-side drain engine.
package fifo_rd_pkg;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} rd_state_t;

endpackage

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a valid/ready stream through a
// 2-entry skid buffer, with packet framing and a delivered-word counter.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int PKT_LEN   = 4,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 r_empty,
  input  logic [DATA_SIZE-1:0] r_data,
  output logic                 r_en,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_last,
  output logic [CNT_SIZE-1:0]  words_out
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(PKT_LEN - 1);

  rd_state_t            state, state_nxt;
  logic [DATA_SIZE-1:0] slot0, slot1;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [CNT_SIZE-1:0]  word_cnt;
  logic                 push, pop;
  logic                 load0, load1, shift;

  // Pop strobe looks only at registered occupancy, never at out_ready.
  assign r_en = !r_empty && (state != ST_TWO) && !flush && !r_rst;
  assign push = r_en;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    load0     = 1'b0;
    load1     = 1'b0;
    shift     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          state_nxt = ST_ONE;
          load0     = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          load0 = 1'b1;
        end else if (push) begin
          state_nxt = ST_TWO;
          load1     = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_nxt = ST_ONE;
          shift     = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      if (load0) begin
        slot0 <= r_data;
      end else if (shift) begin
        slot0 <= slot1;
      end
      if (load1) begin
        slot1 <= r_data;
      end
    end
  end

  // A handshake coinciding with flush still counts as delivered.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      beat_cnt <= '0;
      word_cnt <= '0;
    end else begin
      if (pop) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (flush) begin
        beat_cnt <= '0;
      end else if (pop) begin
        beat_cnt <= (beat_cnt == BEAT_MAX) ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = slot0;
  assign out_last  = out_valid && (beat_cnt == BEAT_MAX);
  assign words_out = word_cnt;

endmodule
